// File: rtl/jtag_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_scan_sequencer                                          |
// | Description : Drives one complete JTAG scan on start: TAP reset, walk to   |
// |               Shift-IR, shift the instruction, walk to Shift-DR, shift the |
// |               data while capturing tdo, then return to Run-Test/Idle.      |
// |               Optional build macro JTAG_SEQ_AUTOSTART_EN runs one sequence |
// |               automatically after reset release.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtag_scan_sequencer #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IR_WIDTH-1:0] instr,
  input  logic [DR_WIDTH-1:0] data,
  input  logic                tdo,
  output logic                tms,
  output logic                tdi,
  output logic                busy,
  output logic                done,
  output logic [DR_WIDTH-1:0] dr_out
);

  // The counter must cover the 5-cycle fixed phases as well as both shifts.
  localparam int MAX_LEN = (IR_WIDTH > DR_WIDTH) ? ((IR_WIDTH > 5) ? IR_WIDTH : 5)
                                                 : ((DR_WIDTH > 5) ? DR_WIDTH : 5);
  localparam int CNT_W   = $clog2(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TAP_RST  = 4'd1,
    IR_WALK  = 4'd2,
    IR_SHIFT = 4'd3,
    IR_EXIT  = 4'd4,
    DR_WALK  = 4'd5,
    DR_SHIFT = 4'd6,
    DR_EXIT  = 4'd7,
    FINISH   = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic [DR_WIDTH-1:0] dr_out_q, dr_out_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                auto_fire;
  logic                trig;

`ifdef JTAG_SEQ_AUTOSTART_EN
  logic [1:0] auto_q;

  // Counts the first two edges after reset release; fires once on the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= 2'd0;
    end else if (auto_q != 2'd2) begin
      auto_q <= auto_q + 2'd1;
    end
  end

  assign auto_fire = (auto_q == 2'd1);
`else
  assign auto_fire = 1'b0;
`endif

  assign trig = start | auto_fire;

  // State register plus the registered TAP-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      instr_q  <= '0;
      data_q   <= '0;
      dr_out_q <= '0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      dr_out_q <= dr_out_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state, then decode of the outputs for the cycle being entered so
  // tms/tdi leave flops aligned with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    instr_d  = instr_q;
    data_d   = data_q;
    dr_out_d = dr_out_q;

    unique case (state_q)
      // FINISH is not busy, so a start seen there chains straight into the
      // next sequence without an idle cycle.
      IDLE, FINISH: begin
        cnt_d   = '0;
        state_d = IDLE;
        if (trig) begin
          state_d = TAP_RST;
          instr_d = instr;
          data_d  = data;
        end
      end
      TAP_RST: if (cnt_q == CNT_W'(4)) begin state_d = IR_WALK; cnt_d = '0; end
      IR_WALK: if (cnt_q == CNT_W'(4)) begin state_d = IR_SHIFT; cnt_d = '0; end
      IR_SHIFT: if (cnt_q == CNT_W'(IR_WIDTH - 1)) begin state_d = IR_EXIT; cnt_d = '0; end
      IR_EXIT: if (cnt_q == CNT_W'(1)) begin state_d = DR_WALK; cnt_d = '0; end
      DR_WALK: if (cnt_q == CNT_W'(2)) begin state_d = DR_SHIFT; cnt_d = '0; end
      DR_SHIFT: begin
        // LSB-first capture: newest bit enters at the top, first bit ends in [0].
        dr_out_d = (dr_out_q >> 1) | (DR_WIDTH'(tdo) << (DR_WIDTH - 1));
        if (cnt_q == CNT_W'(DR_WIDTH - 1)) begin state_d = DR_EXIT; cnt_d = '0; end
      end
      DR_EXIT: if (cnt_q == CNT_W'(1)) begin state_d = FINISH; cnt_d = '0; end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    tms_d  = 1'b1;
    tdi_d  = 1'b0;
    busy_d = (state_d != IDLE) && (state_d != FINISH);
    done_d = (state_d == FINISH);

    unique case (state_d)
      TAP_RST:  tms_d = 1'b1;
      IR_WALK:  tms_d = (cnt_d == CNT_W'(1)) || (cnt_d == CNT_W'(2));
      IR_SHIFT: begin
        tms_d = (cnt_d == CNT_W'(IR_WIDTH - 1));
        tdi_d = |(instr_d & (IR_WIDTH'(1) << cnt_d));
      end
      IR_EXIT:  tms_d = (cnt_d == CNT_W'(0));
      DR_WALK:  tms_d = (cnt_d == CNT_W'(0));
      DR_SHIFT: begin
        tms_d = (cnt_d == CNT_W'(DR_WIDTH - 1));
        tdi_d = |(data_d & (DR_WIDTH'(1) << cnt_d));
      end
      DR_EXIT:  tms_d = (cnt_d == CNT_W'(0));
      default:  tms_d = 1'b1;
    endcase
  end

  assign tms    = tms_q;
  assign tdi    = tdi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign dr_out = dr_out_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtag_scan_sequencer                                       |
// | Description : Randomized self-checking bench against a segment-table model |
// |               of the JTAG scan sequence.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtag_scan_sequencer;
  localparam int IRW = 4;
  localparam int DRW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [IRW-1:0] instr = '0;
  logic [DRW-1:0] data = '0;
  logic           tdo = 1'b0;
  logic           tms, tdi, busy, done;
  logic [DRW-1:0] dr_out;

  jtag_scan_sequencer #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .data(data),
    .tdo(tdo), .tms(tms), .tdi(tdi), .busy(busy), .done(done), .dr_out(dr_out)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  logic [DRW-1:0] prev_dr = '0;

  // Expected per-cycle behaviour of one sequence, built from the segment list.
  bit exp_tms[$];
  bit exp_tdi[$];
  bit is_drs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit t, input bit d, input bit drs);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
    is_drs.push_back(drs);
  endtask

  task automatic build_model(input logic [IRW-1:0] ins, input logic [DRW-1:0] dat);
    bit walk [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tms.delete(); exp_tdi.delete(); is_drs.delete();
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(walk[i], 1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) add(i == IRW - 1, ins[i], 1'b0);
    add(1'b1, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DRW; i++) add(i == DRW - 1, dat[i], 1'b1);
    add(1'b1, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
  endtask

  // Called just after the edge that accepted start; walks k=0.. and FINISH.
  task automatic observe(input logic [IRW-1:0] ins, input logic [DRW-1:0] dat,
                         input bit ones, input int chg_k, input int abort_k);
    logic [DRW-1:0] new_dr;
    int di;
    bit b;
    build_model(ins, dat);
    check("seq_len", exp_tms.size(), 17 + IRW + DRW);
    new_dr = '0;
    di = 0;
    for (int k = 0; k < exp_tms.size(); k++) begin
      if (k == abort_k) return;
      check($sformatf("tms_k%0d", k), tms, exp_tms[k]);
      check($sformatf("tdi_k%0d", k), tdi, exp_tdi[k]);
      check($sformatf("busy_k%0d", k), busy, 1);
      check($sformatf("done_k%0d", k), done, 0);
      if (di == 0 && !is_drs[k]) check("dr_hold", dr_out, prev_dr);
      if (di == DRW) check("dr_after", dr_out, new_dr);
      if (is_drs[k]) begin
        b = ones ? 1'b1 : 1'($urandom_range(0, 1));
        tdo = b;
        new_dr[di] = b;
        di++;
      end else begin
        tdo = 1'($urandom_range(0, 1));
      end
      if (k == chg_k) instr = IRW'($urandom);
      tick();
    end
    check("done_fin", done, 1);
    check("busy_fin", busy, 0);
    check("tdi_fin", tdi, 0);
    check("dr_fin", dr_out, new_dr);
    prev_dr = new_dr;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dr"}, dr_out, prev_dr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [IRW-1:0] a_i;
    logic [DRW-1:0] a_d;
    int gap;

    // Reset values, including a start that must be ignored under reset.
    repeat (3) tick();
    start = 1'b1;
    tick();
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dr", dr_out, 0);
    start = 1'b0;

`ifdef JTAG_SEQ_AUTOSTART_EN
    // One automatic sequence, launched on the second edge after release.
    rst_n = 1'b1;
    a_i = IRW'($urandom); a_d = DRW'($urandom);
    instr = a_i; data = a_d;
    tick();
    check("auto_edge1_busy", busy, 0);
    tick();
    observe(a_i, a_d, 1'b0, -1, -1);
    for (int i = 0; i < 30; i++) begin
      tick();
      check_idle("auto_after");
    end
    a_i = 4'b0010; a_d = 4'b1001;
    instr = a_i; data = a_d; start = 1'b1;
    tick();
`else
    // First start accepted on the first edge after reset release.
    a_i = 4'b0010; a_d = 4'b1001;
    instr = a_i; data = a_d; start = 1'b1; rst_n = 1'b1;
    tick();
`endif
    start = 1'b0;
    observe(a_i, a_d, 1'b1, -1, -1);
    check("dr_ones", dr_out, 4'b1111);
    tick();
    check_idle("idle1");
    tick();
    check_idle("idle2");

    // Start held high: back-to-back sequences, instr change mid-way ignored.
    a_i = IRW'($urandom); a_d = DRW'($urandom);
    instr = a_i; data = a_d; start = 1'b1;
    tick();
    observe(a_i, a_d, 1'b0, 12, -1);
    a_i = instr;
    tick();
    observe(a_i, a_d, 1'b0, -1, -1);
    start = 1'b0;
    tick();
    check_idle("hold_end");

    // Start in the cycle right after done.
    a_i = IRW'($urandom); a_d = DRW'($urandom);
    instr = a_i; data = a_d; start = 1'b1;
    tick();
    start = 1'b0;
    observe(a_i, a_d, 1'b0, -1, -1);
    tick();
    check_idle("after_done");
    a_i = IRW'($urandom); a_d = DRW'($urandom);
    instr = a_i; data = a_d; start = 1'b1;
    tick();
    start = 1'b0;
    observe(a_i, a_d, 1'b0, -1, -1);

    // Reset in the middle of the IR shift.
    instr = IRW'($urandom); data = DRW'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    observe(instr, data, 1'b1, -1, 11);
    rst_n = 1'b0;
    #1;
    check("abort_tms", tms, 1);
    check("abort_tdi", tdi, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dr", dr_out, 0);
    prev_dr = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("in_rst");
    end
    a_i = IRW'($urandom); a_d = DRW'($urandom);
    instr = a_i; data = a_d; start = 1'b1; rst_n = 1'b1;
    tick();
    start = 1'b0;
    observe(a_i, a_d, 1'b0, -1, -1);

    // Random sequences with random idle gaps (gap 0 chains from FINISH).
    for (int n = 0; n < 5; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("gap");
      end
      a_i = IRW'($urandom); a_d = DRW'($urandom);
      instr = a_i; data = a_d; start = 1'b1;
      tick();
      start = 1'b0;
      observe(a_i, a_d, 1'b0, $urandom_range(0, 24), -1);
    end
    tick();
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
